ls_port_arbiter: RTL and testbench

//  Sequences the single-ported SPU local store (LS) among three requesters:
//  DMA line bursts, LSU quadword accesses and instruction-fetch line refills.
//  The IF refill feeds the 64B instruction line buffer; if_done is the refill

---
 rtl/ls_port_if.sv | 36 +++
 rtl/ls_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ls_port_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_port_if.sv
// Local-store port bundle: three requesters (DMA, LSU, IF) on one side, the
// sequenced LS access stream and per-requester grant pulses on the other.
interface ls_port_if #(
  parameter int ADDR_W = 14
);
  // Handshake: a requester holds req (with addr/we stable) until its 1-cycle
  // gnt pulse, which marks the first beat; req seen during the gnt cycle is
  // not a new request, re-requests count from the following cycle on.
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic              dma_gnt;
  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_gnt;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_done;
  logic              ls_en;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [1:0]        ls_src;
  logic              arb_state;

  modport master (
    output dma_req, dma_we, dma_addr, lsu_req, lsu_we, lsu_addr, if_req, if_addr,
    input  dma_gnt, lsu_gnt, if_gnt, if_done, ls_en, ls_we, ls_addr, ls_src, arb_state
  );

  modport slave (
    input  dma_req, dma_we, dma_addr, lsu_req, lsu_we, lsu_addr, if_req, if_addr,
    output dma_gnt, lsu_gnt, if_gnt, if_done, ls_en, ls_we, ls_addr, ls_src, arb_state
  );
endinterface

// File: rtl/ls_port_arbiter.sv
// Single-port local-store sequencer: DMA > LSU > IF, non-preemptible bursts.
// Optional IF anti-starvation guard enabled by defining LS_ARB_STARVE_EN.
module ls_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DMA_BEATS  = 8,
  parameter int IF_BEATS   = 4,
  parameter int STARVE_MAX = 16
) (
  input logic     clk,
  input logic     reset,
  ls_port_if.slave bus
);

  localparam int MAX_BEATS = (DMA_BEATS > IF_BEATS) ? DMA_BEATS : IF_BEATS;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_DMA  = 2'b01;
  localparam logic [1:0] SRC_LSU  = 2'b10;
  localparam logic [1:0] SRC_IF   = 2'b11;

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t            state;
  logic [CNT_W-1:0]  beats_left;
  logic              arb_point;
  logic              dma_ok, lsu_ok, if_ok, if_force;
  logic [1:0]        win_src;
  logic [ADDR_W-1:0] win_addr;
  logic              win_we;
  logic [CNT_W-1:0]  win_left;

  assign bus.arb_state = state;

  // A requester whose gnt is on the bus right now is already being served.
  assign dma_ok = bus.dma_req && !bus.dma_gnt;
  assign lsu_ok = bus.lsu_req && !bus.lsu_gnt;
  assign if_ok  = bus.if_req  && !bus.if_gnt;

`ifdef LS_ARB_STARVE_EN
  localparam int ST_W = $clog2(STARVE_MAX + 1);
  logic [ST_W-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (reset || !bus.if_req || bus.if_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != ST_W'(STARVE_MAX)) begin
      starve_cnt <= starve_cnt + ST_W'(1);
    end
  end

  assign if_force = if_ok && (starve_cnt == ST_W'(STARVE_MAX));
`else
  assign if_force = 1'b0;
`endif

  always_comb begin
    arb_point = (state == S_IDLE) || (beats_left == '0);
    win_src   = SRC_NONE;
    win_addr  = '0;
    win_we    = 1'b0;
    win_left  = '0;
    if (if_force) begin
      win_src  = SRC_IF;
      win_addr = bus.if_addr;
      win_left = CNT_W'(IF_BEATS - 1);
    end else if (dma_ok) begin
      win_src  = SRC_DMA;
      win_addr = bus.dma_addr;
      win_we   = bus.dma_we;
      win_left = CNT_W'(DMA_BEATS - 1);
    end else if (lsu_ok) begin
      win_src  = SRC_LSU;
      win_addr = bus.lsu_addr;
      win_we   = bus.lsu_we;
    end else if (if_ok) begin
      win_src  = SRC_IF;
      win_addr = bus.if_addr;
      win_left = CNT_W'(IF_BEATS - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      beats_left  <= '0;
      bus.ls_en   <= 1'b0;
      bus.ls_we   <= 1'b0;
      bus.ls_addr <= '0;
      bus.ls_src  <= SRC_NONE;
      bus.dma_gnt <= 1'b0;
      bus.lsu_gnt <= 1'b0;
      bus.if_gnt  <= 1'b0;
      bus.if_done <= 1'b0;
    end else begin
      bus.dma_gnt <= 1'b0;
      bus.lsu_gnt <= 1'b0;
      bus.if_gnt  <= 1'b0;
      bus.if_done <= 1'b0;
      if (arb_point) begin
        if (win_src != SRC_NONE) begin
          state       <= S_BURST;
          beats_left  <= win_left;
          bus.ls_en   <= 1'b1;
          bus.ls_we   <= win_we;
          bus.ls_addr <= win_addr;
          bus.ls_src  <= win_src;
          bus.dma_gnt <= (win_src == SRC_DMA);
          bus.lsu_gnt <= (win_src == SRC_LSU);
          bus.if_gnt  <= (win_src == SRC_IF);
          bus.if_done <= (win_src == SRC_IF) && (win_left == '0);
        end else begin
          state       <= S_IDLE;
          beats_left  <= '0;
          bus.ls_en   <= 1'b0;
          bus.ls_we   <= 1'b0;
          bus.ls_addr <= '0;
          bus.ls_src  <= SRC_NONE;
        end
      end else begin
        // Mid-burst: address wraps naturally at ADDR_W bits.
        beats_left  <= beats_left - CNT_W'(1);
        bus.ls_addr <= bus.ls_addr + ADDR_W'(1);
        bus.if_done <= (bus.ls_src == SRC_IF) && (beats_left == CNT_W'(1));
      end
    end
  end

endmodule

// File: tb/tb_ls_port_arbiter.sv
// Bench for ls_port_arbiter: directed scenarios plus random traffic, checked
// against a queue-of-planned-beats reference model.
module tb_ls_port_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DMA_BEATS  = 8;
  localparam int IF_BEATS   = 4;
  localparam int STARVE_MAX = 16;
`ifdef LS_ARB_STARVE_EN
  localparam bit STARVE_EN  = 1'b1;
`else
  localparam bit STARVE_EN  = 1'b0;
`endif

  localparam logic [1:0] S_NONE = 2'b00;
  localparam logic [1:0] S_DMA  = 2'b01;
  localparam logic [1:0] S_LSU  = 2'b10;
  localparam logic [1:0] S_IF   = 2'b11;

  typedef struct packed {
    logic [1:0]        src;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              gnt;
    logic              done;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ls_port_if #(.ADDR_W(ADDR_W)) bus();

  ls_port_arbiter #(
    .ADDR_W(ADDR_W), .DMA_BEATS(DMA_BEATS), .IF_BEATS(IF_BEATS), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  beat_t exp_q[$];
  int    starve;
  int    total = 0;
  int    bad = 0;
  bit    rand_en = 1'b0;
  bit    hold_dma = 1'b0;
  int    p_dma = 0, p_lsu = 0, p_if = 0;

  // Model: at an arbitration point (nothing queued beyond the current beat)
  // append the winner's whole burst; then advance one clock and check.
  task automatic step();
    beat_t cur, b;
    logic [1:0] g, win;
    logic d, l, i, v;
    int len;
    logic [ADDR_W-1:0] a;
    logic w;
    if (reset) begin
      exp_q.delete();
      starve = 0;
    end else begin
      cur = '0;
      if (exp_q.size() > 0) cur = exp_q[0];
      g = cur.gnt ? cur.src : S_NONE;
      d = bus.dma_req && (g != S_DMA);
      l = bus.lsu_req && (g != S_LSU);
      i = bus.if_req  && (g != S_IF);
      win = S_NONE;
      if (exp_q.size() <= 1) begin
        if (STARVE_EN && i && starve == STARVE_MAX) win = S_IF;
        else if (d) win = S_DMA;
        else if (l) win = S_LSU;
        else if (i) win = S_IF;
      end
      if (!bus.if_req || g == S_IF) starve = 0;
      else if (starve < STARVE_MAX) starve++;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      case (win)
        S_DMA:   begin len = DMA_BEATS; a = bus.dma_addr; w = bus.dma_we; end
        S_LSU:   begin len = 1;         a = bus.lsu_addr; w = bus.lsu_we; end
        S_IF:    begin len = IF_BEATS;  a = bus.if_addr;  w = 1'b0;       end
        default: begin len = 0;         a = '0;           w = 1'b0;       end
      endcase
      for (int k = 0; k < len; k++) begin
        b.src  = win;
        b.addr = a + ADDR_W'(k);
        b.we   = w;
        b.gnt  = (k == 0);
        b.done = (win == S_IF) && (k == len - 1);
        exp_q.push_back(b);
      end
    end
    @(negedge clk);
    cur = '0;
    v = (exp_q.size() > 0);
    if (v) cur = exp_q[0];
    total++;
    if ({bus.ls_en, bus.ls_src, bus.ls_we, bus.dma_gnt, bus.lsu_gnt, bus.if_gnt, bus.if_done} !==
        {v, cur.src, cur.we, cur.gnt && cur.src == S_DMA, cur.gnt && cur.src == S_LSU,
         cur.gnt && cur.src == S_IF, cur.done} || (v && bus.ls_addr !== cur.addr)) begin
      bad++;
      $display("FAIL beat t=%0t got en=%0b src=%0d we=%0b addr=%h gnt(d/l/i)=%0b%0b%0b done=%0b expected en=%0b src=%0d we=%0b addr=%h gnt=%0b done=%0b",
               $time, bus.ls_en, bus.ls_src, bus.ls_we, bus.ls_addr, bus.dma_gnt, bus.lsu_gnt,
               bus.if_gnt, bus.if_done, v, cur.src, cur.we, cur.addr, cur.gnt, cur.done);
    end
    g = cur.gnt ? cur.src : S_NONE;
    if (g == S_DMA && !hold_dma) bus.dma_req = 1'b0;
    if (g == S_LSU) bus.lsu_req = 1'b0;
    if (g == S_IF)  bus.if_req  = 1'b0;
    if (rand_en) begin
      if (!bus.dma_req && $urandom_range(0, 99) < p_dma) begin
        bus.dma_req  = 1'b1;
        bus.dma_addr = ADDR_W'($urandom);
        bus.dma_we   = 1'($urandom_range(0, 1));
      end else if (bus.dma_req && g != S_DMA && $urandom_range(0, 99) < 2) begin
        bus.dma_req = 1'b0;
      end
      if (!bus.lsu_req && $urandom_range(0, 99) < p_lsu) begin
        bus.lsu_req  = 1'b1;
        bus.lsu_addr = ADDR_W'($urandom);
        bus.lsu_we   = 1'($urandom_range(0, 1));
      end else if (bus.lsu_req && g != S_LSU && $urandom_range(0, 99) < 2) begin
        bus.lsu_req = 1'b0;
      end
      if (!bus.if_req && $urandom_range(0, 99) < p_if) begin
        bus.if_req  = 1'b1;
        bus.if_addr = ADDR_W'($urandom_range(0, (1 << ADDR_W) / IF_BEATS - 1) * IF_BEATS);
      end else if (bus.if_req && g != S_IF && $urandom_range(0, 99) < 2) begin
        bus.if_req = 1'b0;
      end
    end
  endtask

  task automatic drain();
    rand_en     = 1'b0;
    hold_dma    = 1'b0;
    bus.dma_req = 1'b0;
    bus.lsu_req = 1'b0;
    bus.if_req  = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total++;
    if ({bus.ls_en, bus.ls_src, bus.ls_we, bus.ls_addr, bus.dma_gnt, bus.lsu_gnt, bus.if_gnt,
         bus.if_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got en=%0b src=%0d we=%0b addr=%h gnt=%0b%0b%0b done=%0b expected all 0",
               bus.ls_en, bus.ls_src, bus.ls_we, bus.ls_addr, bus.dma_gnt, bus.lsu_gnt,
               bus.if_gnt, bus.if_done);
    end
    reset = 1'b0;
  endtask

  task automatic test_if_refill();
    bus.if_addr = 14'h0040;
    bus.if_req  = 1'b1;
    for (int k = 0; k < IF_BEATS; k++) begin
      step();
      total++;
      if (bus.ls_addr !== 14'h0040 + 14'(k) || bus.ls_src !== S_IF || bus.ls_we !== 1'b0 ||
          bus.if_gnt !== (k == 0) || bus.if_done !== (k == IF_BEATS - 1)) begin
        bad++;
        $display("FAIL if_refill beat %0d: got addr=%h src=%0d we=%0b gnt=%0b done=%0b expected addr=%h src=3 we=0 gnt=%0b done=%0b",
                 k, bus.ls_addr, bus.ls_src, bus.ls_we, bus.if_gnt, bus.if_done,
                 14'h0040 + 14'(k), k == 0, k == IF_BEATS - 1);
      end
    end
    drain();
  endtask

  task automatic test_priority();
    int en_cnt;
    logic [1:0] es;
    en_cnt = 0;
    bus.dma_addr = 14'h0100; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    bus.lsu_addr = 14'h0200; bus.lsu_we = 1'b1; bus.lsu_req = 1'b1;
    bus.if_addr  = 14'h0300;                    bus.if_req  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step();
      if (bus.ls_en) en_cnt++;
      es = (k < 8) ? S_DMA : (k == 8) ? S_LSU : (k < 13) ? S_IF : S_NONE;
      total++;
      if (bus.ls_src !== es) begin
        bad++;
        $display("FAIL priority_order cycle %0d: got src=%0d expected %0d", k + 1, bus.ls_src, es);
      end
    end
    total++;
    if (en_cnt != 13) begin
      bad++;
      $display("FAIL priority_en_count: got %0d expected 13", en_cnt);
    end
    drain();
  endtask

  task automatic test_dma_wrap();
    logic [ADDR_W-1:0] ea;
    bus.dma_addr = 14'h3FFE; bus.dma_we = 1'b1; bus.dma_req = 1'b1;
    for (int k = 0; k < DMA_BEATS; k++) begin
      step();
      ea = 14'h3FFE + 14'(k);
      total++;
      if (bus.ls_addr !== ea || bus.ls_we !== 1'b1 || bus.ls_src !== S_DMA) begin
        bad++;
        $display("FAIL dma_wrap beat %0d: got addr=%h we=%0b src=%0d expected addr=%h we=1 src=1",
                 k, bus.ls_addr, bus.ls_we, bus.ls_src, ea);
      end
    end
    drain();
  endtask

  task automatic test_lsu_mid_if();
    bus.if_addr = 14'h0100; bus.if_req = 1'b1;
    step();
    step();
    bus.lsu_addr = 14'h0055; bus.lsu_we = 1'b1; bus.lsu_req = 1'b1;
    step();
    step();
    total++;
    if (bus.ls_src !== S_IF || bus.if_done !== 1'b1 || bus.ls_addr !== 14'h0103) begin
      bad++;
      $display("FAIL lsu_mid_if last_if_beat: got src=%0d done=%0b addr=%h expected src=3 done=1 addr=0103",
               bus.ls_src, bus.if_done, bus.ls_addr);
    end
    step();
    total++;
    if (bus.lsu_gnt !== 1'b1 || bus.ls_src !== S_LSU || bus.ls_addr !== 14'h0055) begin
      bad++;
      $display("FAIL lsu_mid_if lsu_beat: got gnt=%0b src=%0d addr=%h expected gnt=1 src=2 addr=0055",
               bus.lsu_gnt, bus.ls_src, bus.ls_addr);
    end
    drain();
  endtask

  task automatic test_starve();
    int first_if, exp_first;
    first_if  = 0;
    exp_first = STARVE_EN ? 17 : 0;
    bus.dma_addr = 14'h0800; bus.dma_we = 1'b0; bus.dma_req = 1'b1;
    bus.if_addr  = 14'h0400; bus.if_req = 1'b1;
    hold_dma = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (bus.if_gnt && first_if == 0) first_if = n;
    end
    total++;
    if (first_if != exp_first) begin
      bad++;
      $display("FAIL starve_if_gnt_cycle: got %0d expected %0d", first_if, exp_first);
    end
    drain();
  endtask

  task automatic test_reset_mid_burst();
    bus.dma_addr = 14'h0200; bus.dma_we = 1'b1; bus.dma_req = 1'b1;
    repeat (3) step();
    reset = 1'b1;
    step();
    total++;
    if ({bus.ls_en, bus.ls_src, bus.ls_we, bus.ls_addr, bus.dma_gnt, bus.lsu_gnt, bus.if_gnt,
         bus.if_done} !== '0) begin
      bad++;
      $display("FAIL reset_mid_burst: got en=%0b src=%0d we=%0b addr=%h gnt=%0b%0b%0b done=%0b expected all 0",
               bus.ls_en, bus.ls_src, bus.ls_we, bus.ls_addr, bus.dma_gnt, bus.lsu_gnt,
               bus.if_gnt, bus.if_done);
    end
    reset = 1'b0;
    bus.dma_req = 1'b0;
    bus.lsu_addr = 14'h0123; bus.lsu_we = 1'b0; bus.lsu_req = 1'b1;
    step();
    total++;
    if (bus.lsu_gnt !== 1'b1 || bus.ls_addr !== 14'h0123 || bus.ls_en !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_lsu: got gnt=%0b en=%0b addr=%h expected gnt=1 en=1 addr=0123",
               bus.lsu_gnt, bus.ls_en, bus.ls_addr);
    end
    drain();
  endtask

  task automatic test_random();
    p_dma = 8; p_lsu = 30; p_if = 15;
    rand_en = 1'b1;
    repeat (3000) step();
    drain();
  endtask

  initial begin
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0;
    bus.if_req  = 1'b0; bus.if_addr = '0;
    starve = 0;
    test_reset();
    test_if_refill();
    test_priority();
    test_dma_wrap();
    test_lsu_mid_if();
    test_starve();
    test_reset_mid_burst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
